// File: rtl/fp16_mul_arbiter.sv
// Round-robin front end that shares one fixed-latency FP16 multiplier among NREQ requesters.
// Define FP16_MUL_ARB_STATS_EN to add per-requester saturating grant counters (grant_cnt_o).
module fp16_mul_arbiter #(
    parameter int DW   = 16,
    parameter int NREQ = 4,
    parameter int LAT  = 6,
    parameter int IW   = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*DW-1:0]   req_a_i,
    input  logic [NREQ*DW-1:0]   req_b_i,
    output logic [NREQ-1:0]      rsp_valid_o,
    output logic [DW-1:0]        rsp_p_o,
    output logic                 mul_valid_o,
    output logic [DW-1:0]        mul_a_o,
    output logic [DW-1:0]        mul_b_o,
    input  logic                 mul_valid_i,
    input  logic [DW-1:0]        mul_p_i,
    output logic                 err_o
`ifdef FP16_MUL_ARB_STATS_EN
   ,output logic [NREQ*16-1:0]   grant_cnt_o
`endif
);

    logic [NREQ-1:0][DW-1:0] a_arr, b_arr;
    logic [IW-1:0]           ptr, gnt_idx, cand, iss_idx;
    logic                    gnt_any, hs;
    logic [LAT:1]            vld_pipe;
    logic [LAT:1][IW-1:0]    tag_idx;

    assign a_arr = req_a_i;
    assign b_arr = req_b_i;

    // Scan from the farthest offset down so the nearest requester after ptr wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = NREQ; i >= 1; i--) begin
            cand = IW'((int'(ptr) + i) % NREQ);
            if (req_valid_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Ready is held low while reset is asserted so nothing is accepted mid-reset.
    assign req_ready_o = (rstn && gnt_any) ? (NREQ'(1) << gnt_idx) : '0;
    assign hs          = |(req_valid_i & req_ready_o);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ptr         <= IW'(NREQ - 1);
            mul_valid_o <= 1'b0;
            mul_a_o     <= '0;
            mul_b_o     <= '0;
            iss_idx     <= '0;
        end else begin
            mul_valid_o <= hs;
            if (hs) begin
                ptr     <= gnt_idx;
                mul_a_o <= a_arr[gnt_idx];
                mul_b_o <= b_arr[gnt_idx];
                iss_idx <= gnt_idx;
            end
        end
    end

    // Stage LAT lines up with the multiplier's valid_o.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_pipe <= '0;
            tag_idx  <= '0;
        end else begin
            vld_pipe[1] <= mul_valid_o;
            tag_idx[1]  <= iss_idx;
            for (int s = 2; s <= LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                tag_idx[s]  <= tag_idx[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_valid_o <= '0;
            rsp_p_o     <= '0;
            err_o       <= 1'b0;
        end else begin
            rsp_valid_o <= '0;
            if (mul_valid_i && vld_pipe[LAT]) begin
                rsp_valid_o <= NREQ'(1) << tag_idx[LAT];
                rsp_p_o     <= mul_p_i;
            end
            if (mul_valid_i != vld_pipe[LAT])
                err_o <= 1'b1;
        end
    end

`ifdef FP16_MUL_ARB_STATS_EN
    logic [NREQ-1:0][15:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else begin
            for (int k = 0; k < NREQ; k++)
                if (hs && gnt_idx == IW'(k) && cnt[k] != 16'hFFFF)
                    cnt[k] <= cnt[k] + 16'd1;
        end
    end

    assign grant_cnt_o = cnt;
`else
    // Without the stats build no grant history is kept.
`endif

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed bench for fp16_mul_arbiter with a LAT-deep FP16 multiplier model.
// Covers reset, single issue latency, rotation, fairness, mismatch, mid-flight reset and stats.
module tb_fp16_mul_arbiter;
    localparam int DW = 16, NREQ = 4, LAT = 6, IW = 2;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NREQ-1:0]     req_valid_i, req_ready_o, rsp_valid_o;
    logic [NREQ*DW-1:0]  req_a_i, req_b_i;
    logic [DW-1:0]       rsp_p_o, mul_a_o, mul_b_o, mul_p_i;
    logic                mul_valid_o, mul_valid_i, err_o;
    logic                inj;
`ifdef FP16_MUL_ARB_STATS_EN
    logic [NREQ*16-1:0]  grant_cnt;
`endif

    always #5 clk = ~clk;

    fp16_mul_arbiter #(.DW(DW), .NREQ(NREQ), .LAT(LAT), .IW(IW)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i),
        .rsp_valid_o(rsp_valid_o), .rsp_p_o(rsp_p_o),
        .mul_valid_o(mul_valid_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_valid_i(mul_valid_i), .mul_p_i(mul_p_i),
        .err_o(err_o)
`ifdef FP16_MUL_ARB_STATS_EN
       ,.grant_cnt_o(grant_cnt)
`endif
    );

    // Exact-product FP16 multiply for normal operands (truncating).
    function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
        logic        s;
        int          e;
        logic [21:0] m;
        s = a[15] ^ b[15];
        e = int'(a[14:10]) + int'(b[14:10]) - 15;
        m = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
        if (m[21]) begin e++; m = m >> 11; end
        else m = m >> 10;
        return {s, e[4:0], m[9:0]};
    endfunction

    logic [LAT:1]       mv;
    logic [LAT:1][15:0] mp;
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mv <= '0;
            mp <= '0;
        end else begin
            mv <= {mv[LAT-1:1], mul_valid_o};
            mp <= {mp[LAT-1:1], fmul(mul_a_o, mul_b_o)};
        end
    end
    assign mul_valid_i = mv[LAT] | inj;
    assign mul_p_i     = mp[LAT];

    logic [15:0] op_a [4] = '{16'h3C00, 16'h4000, 16'h3E00, 16'hBC00};
    logic [15:0] op_b [4] = '{16'h4000, 16'h4200, 16'h3E00, 16'h4400};
    logic [15:0] prod [4] = '{16'h4000, 16'h4600, 16'h4080, 16'hC400};

    int n_chk = 0, n_fail = 0, cyc = 0;
    int rq_cyc[$];
    logic [NREQ-1:0] rq_v[$];
    logic [DW-1:0]   rq_p[$];
    int exp_g[$];
    logic [NREQ-1:0] s_rdy, s_rv;
    logic [DW-1:0]   s_ma, s_mb, s_rp;
    logic            s_mv, s_err;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Sample at the falling edge, log responses, then move to just after the next rising edge.
    task automatic tick();
        @(negedge clk);
        s_rdy = req_ready_o; s_mv = mul_valid_o; s_ma = mul_a_o; s_mb = mul_b_o;
        s_rv = rsp_valid_o; s_rp = rsp_p_o; s_err = err_o;
        if (rsp_valid_o != '0) begin
            rq_cyc.push_back(cyc);
            rq_v.push_back(rsp_valid_o);
            rq_p.push_back(rsp_p_o);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clr_log();
        rq_cyc.delete(); rq_v.delete(); rq_p.delete(); exp_g.delete();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rdy"}, 64'(s_rdy), 64'd0);
        chk({tag, "_mv"},  64'(s_mv),  64'd0);
        chk({tag, "_ma"},  64'(s_ma),  64'd0);
        chk({tag, "_mb"},  64'(s_mb),  64'd0);
        chk({tag, "_rv"},  64'(s_rv),  64'd0);
        chk({tag, "_rp"},  64'(s_rp),  64'd0);
        chk({tag, "_err"}, 64'(s_err), 64'd0);
    endtask

    // Handshakes occurred on consecutive cycles from base, in exp_g order.
    task automatic check_rsps(input string tag, input int base, input int n);
        chk({tag, "_nrsp"}, 64'(rq_v.size()), 64'(n));
        for (int j = 0; j < n && j < rq_v.size(); j++) begin
            chk($sformatf("%s_v%0d", tag, j),   64'(rq_v[j]),   64'(1 << exp_g[j]));
            chk($sformatf("%s_p%0d", tag, j),   64'(rq_p[j]),   64'(prod[exp_g[j]]));
            chk($sformatf("%s_cyc%0d", tag, j), 64'(rq_cyc[j]), 64'(base + j + LAT + 2));
        end
    endtask

    initial begin
        rstn = 1'b0; inj = 1'b0; req_valid_i = 4'hF;
        for (int k = 0; k < NREQ; k++) begin
            req_a_i[k*DW +: DW] = op_a[k];
            req_b_i[k*DW +: DW] = op_b[k];
        end
        @(posedge clk); #1;
        tick();
        chk_all_zero("rst");
        rstn = 1'b1; req_valid_i = '0;
        tick();

        // Single request on req0, exact LAT+2 response latency
        req_valid_i = 4'b0001; tick();
        chk("t1_rdy", 64'(s_rdy), 64'h1);
        req_valid_i = '0; tick();
        chk("t1_mv", 64'(s_mv), 64'h1);
        chk("t1_ma", 64'(s_ma), 64'h3C00);
        chk("t1_mb", 64'(s_mb), 64'h4000);
        tick();
        chk("t1_mv_off", 64'(s_mv), 64'h0);
        chk("t1_ma_hold", 64'(s_ma), 64'h3C00);
        repeat (LAT - 1) tick();
        chk("t1_rv_early", 64'(s_rv), 64'h0);
        tick();
        chk("t1_rv", 64'(s_rv), 64'h1);
        chk("t1_rp", 64'(s_rp), 64'h4000);
        tick();
        chk("t1_rv_off", 64'(s_rv), 64'h0);
        chk("t1_rp_hold", 64'(s_rp), 64'h4000);

        // All four valid for 8 cycles: rotation 0,1,2,3,0,1,2,3
        do_reset();
        clr_log();
        begin
            int base;
            base = cyc;
            for (int i = 0; i < 8; i++) begin
                req_valid_i = 4'hF; tick();
                chk($sformatf("t2_rdy%0d", i), 64'(s_rdy), 64'(1 << (i % 4)));
                exp_g.push_back(i % 4);
            end
            req_valid_i = '0;
            repeat (LAT + 4) tick();
            check_rsps("t2", base, 8);
        end

        // Fairness: req2 held, req0 pulses every 3rd cycle, req1 appears once and drops unserved
        clr_log();
        begin
            int base;
            base = cyc;
            for (int i = 0; i < 12; i++) begin
                req_valid_i = 4'b0100 | ((i % 3 == 0) ? 4'b0001 : 4'b0000) | ((i == 3) ? 4'b0010 : 4'b0000);
                tick();
                exp_g.push_back((i % 3 == 0) ? 0 : 2);
                chk($sformatf("t3_rdy%0d", i), 64'(s_rdy), 64'(1 << exp_g[i]));
            end
            req_valid_i = '0;
            repeat (LAT + 4) tick();
            check_rsps("t3", base, 12);
        end

        // Spurious multiplier valid with nothing in flight
        clr_log();
        tick();
        chk("t4_err_pre", 64'(s_err), 64'h0);
        inj = 1'b1; tick();
        inj = 1'b0; tick();
        chk("t4_err", 64'(s_err), 64'h1);
        chk("t4_rv", 64'(s_rv), 64'h0);
        repeat (4) tick();
        chk("t4_err_sticky", 64'(s_err), 64'h1);
        chk("t4_nrsp", 64'(rq_v.size()), 64'd0);

        // Reset with three ops in flight
        req_valid_i = 4'b0111; repeat (3) tick();
        req_valid_i = '0; tick();
        rstn = 1'b0; req_valid_i = 4'hF; tick();
        chk_all_zero("t5");
        rstn = 1'b1; req_valid_i = '0;
        clr_log();
        repeat (LAT + 4) tick();
        chk("t5_nrsp", 64'(rq_v.size()), 64'd0);
        chk("t5_err", 64'(s_err), 64'h0);
        req_valid_i = 4'hF; tick();
        chk("t5_first", 64'(s_rdy), 64'h1);
        req_valid_i = '0; tick();

`ifdef FP16_MUL_ARB_STATS_EN
        do_reset();
        chk("t6_cnt_rst", 64'(grant_cnt), 64'd0);
        req_valid_i = 4'b0010; repeat (5) tick();
        req_valid_i = 4'b1000; repeat (2) tick();
        req_valid_i = '0; tick();
        chk("t6_cnt0", 64'(grant_cnt[0*16 +: 16]), 64'd0);
        chk("t6_cnt1", 64'(grant_cnt[1*16 +: 16]), 64'd5);
        chk("t6_cnt2", 64'(grant_cnt[2*16 +: 16]), 64'd0);
        chk("t6_cnt3", 64'(grant_cnt[3*16 +: 16]), 64'd2);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
